// File: rtl/common_memory_ctrl.sv
// Single-port word memory with a valid/ready request channel, byte-enable writes and
// incrementing read bursts under response backpressure. Optional feature macro: MEM_PARITY_EN.
module common_memory_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int BURST_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_adr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [BURST_W-1:0]  req_len,
`ifdef MEM_PARITY_EN
    input  logic                par_inj,
    output logic                rsp_perr,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_last,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, RD} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  next_adr;
    logic [BURST_W-1:0] remain;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic              rsp_free;
    logic              wr_fire;
    logic              rd_fire;
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_word;

    // The output slot can take a new beat when it is empty or being drained this cycle.
    assign rsp_free  = !rsp_valid || rsp_ready;
    assign req_ready = rst_n && (state == IDLE) && rsp_free;
    assign wr_fire   = req_valid && req_ready && req_wr;
    assign rd_fire   = req_valid && req_ready && !req_wr;
    assign rd_adr    = (state == IDLE) ? req_adr : next_adr;
    assign rd_word   = mem[rd_adr];

`ifdef MEM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] rd_par;
    logic             rd_perr;

    assign rd_par = par_mem[rd_adr];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_perr = 1'b1;
        end
    end
`endif

    // NOTE: the RAM array has no reset; its contents survive rst_n, only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_be[i]) begin
                    mem[req_adr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
                    par_mem[req_adr][i] <= (^req_wdata[8*i +: 8]) ^ par_inj;
`endif
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            next_adr  <= '0;
            remain    <= '0;
`ifdef MEM_PARITY_EN
            rsp_perr  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_fire) begin
                        rsp_data  <= rd_word;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (req_len == '0);
`ifdef MEM_PARITY_EN
                        rsp_perr  <= rd_perr;
`endif
                        if (req_len != '0) begin
                            state    <= RD;
                            busy     <= 1'b1;
                            next_adr <= req_adr + 1'b1;
                            remain   <= req_len;
                        end
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
`ifdef MEM_PARITY_EN
                        rsp_perr  <= 1'b0;
`endif
                    end
                end
                RD: begin
                    // Stalled beats stay untouched until the consumer takes them.
                    if (rsp_free) begin
                        rsp_data  <= rd_word;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (remain == BURST_W'(1));
`ifdef MEM_PARITY_EN
                        rsp_perr  <= rd_perr;
`endif
                        next_adr  <= next_adr + 1'b1;
                        remain    <= remain - 1'b1;
                        if (remain == BURST_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_common_memory_ctrl.sv
// Directed scoreboard bench for common_memory_ctrl: a model predicts each read beat at issue,
// and a negedge monitor pops and compares every beat the consumer takes.
module tb_common_memory_ctrl;

    localparam int DEPTH = 512;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        perr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [8:0]  req_adr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic [3:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;
`ifdef MEM_PARITY_EN
    logic        par_inj = 1'b0;
    logic        rsp_perr;
`endif

    beat_t       sb[$];
    logic [31:0] mdl     [DEPTH];
    logic [3:0]  mdl_bad [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    time         first_pop = 0;
    time         last_pop = 0;

    common_memory_ctrl #(.DATA_W(32), .ADDR_W(9), .BURST_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_len   (req_len),
`ifdef MEM_PARITY_EN
        .par_inj   (par_inj),
        .rsp_perr  (rsp_perr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, update the model / scoreboard, wait (bounded) for acceptance.
    task automatic issue(input logic wr, input logic [8:0] adr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [3:0] len, input logic inj);
        int   n;
        logic [8:0] a;
        beat_t b;
        req_valid = 1'b1;
        req_wr    = wr;
        req_adr   = adr;
        req_wdata = wdata;
        req_be    = be;
        req_len   = len;
`ifdef MEM_PARITY_EN
        par_inj   = inj;
`endif
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mdl[adr][8*i +: 8] = wdata[8*i +: 8];
                    mdl_bad[adr][i]    = inj;
                end
            end
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                a      = adr + 9'(i);
                b.data = mdl[a];
                b.last = (i == int'(len));
                b.perr = |mdl_bad[a];
                sb.push_back(b);
            end
        end
        #1;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) check("req_accept_timeout", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        req_adr   = 9'($urandom);
        req_wdata = $urandom;
        req_len   = 4'($urandom);
`ifdef MEM_PARITY_EN
        par_inj   = 1'b0;
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'(rsp_data), 64'hDEAD_0000);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_last", 64'(rsp_last), 64'(e.last));
`ifdef MEM_PARITY_EN
                check("rsp_perr", 64'(rsp_perr), 64'(e.perr));
`endif
                pops++;
                if (pops == 1) first_pop = $time;
                last_pop = $time;
            end
        end
    end

    initial begin
        logic [3:0] pat;
        int         n;
        pat = 4'b1001;

        // Reset values
        repeat (3) tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_last",  64'(rsp_last),  64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_req_ready", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;

        // 1: single write then single read, one-cycle latency
        issue(1'b1, 9'd10, 32'h0000_0001, 4'hF, 4'd0, 1'b0);
        issue(1'b0, 9'd10, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_data",  64'(rsp_data),  64'h0000_0001);
        check("t1_last",  64'(rsp_last),  64'd1);
        drain("t1_drain");

        // 2: byte-enable merge, be==0 is a no-op
        issue(1'b1, 9'd3, 32'hAABB_CCDD, 4'hF, 4'd0, 1'b0);
        issue(1'b1, 9'd3, 32'h1122_3344, 4'h5, 4'd0, 1'b0);
        issue(1'b1, 9'd3, 32'hFFFF_FFFF, 4'h0, 4'd0, 1'b0);
        issue(1'b0, 9'd3, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t2_data", 64'(rsp_data), 64'hAA22_CC44);
        drain("t2_drain");

        // 3: wrapping burst at full throughput
        for (int a = 500; a < 512; a++) issue(1'b1, 9'(a), 32'(a), 4'hF, 4'd0, 1'b0);
        for (int a = 0; a < 8; a++)     issue(1'b1, 9'(a), 32'(a), 4'hF, 4'd0, 1'b0);
        pops = 0;
        issue(1'b0, 9'd508, 32'h0, 4'h0, 4'd7, 1'b0);
        check("t3_busy_hi", 64'(busy), 64'd1);
        drain("t3_drain");
        check("t3_beats", 64'(pops), 64'd8);
        check("t3_span",  64'(last_pop - first_pop), 64'd70);
        check("t3_busy_lo", 64'(busy), 64'd0);

        // 4: same burst with rsp_ready pattern 1,0,0,1,...
        pops = 0;
        issue(1'b0, 9'd508, 32'h0, 4'h0, 4'd7, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            rsp_ready = pat[n % 4];
            #1;
            if (sb.size() > 1) check("t4_req_ready", 64'(req_ready), 64'd0);
            if (rsp_valid && sb.size() > 0) check("t4_hold", 64'(rsp_data), 64'(sb[0].data));
            tick();
            n++;
        end
        check("t4_drain", 64'(sb.size()), 64'd0);
        check("t4_beats", 64'(pops), 64'd8);
        rsp_ready = 1'b1;
        tick();
        check("t4_ready_after", 64'(req_ready), 64'd1);

        // Maximum-length burst with random backpressure
        pops = 0;
        issue(1'b0, 9'd504, 32'h0, 4'h0, 4'd15, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("max_drain", 64'(sb.size()), 64'd0);
        check("max_beats", 64'(pops), 64'd16);
        rsp_ready = 1'b1;
        tick();

        // 5: reset in the middle of a burst
        pops = 0;
        issue(1'b0, 9'd508, 32'h0, 4'h0, 4'd7, 1'b0);
        n = 0;
        while (pops < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t5_three_beats", 64'(pops), 64'd3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_rsp_last",  64'(rsp_last),  64'd0);
        check("t5_rsp_data",  64'(rsp_data),  64'd0);
        check("t5_busy",      64'(busy),      64'd0);
        check("t5_req_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_beat", 64'(rsp_valid), 64'd0);
        end
        issue(1'b0, 9'd0, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t5_adr0", 64'(rsp_data), 64'd0);
        drain("t5_drain0");
        issue(1'b0, 9'd511, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t5_adr511", 64'(rsp_data), 64'd511);
        drain("t5_drain511");

`ifdef MEM_PARITY_EN
        // 6: parity injection and recovery
        issue(1'b1, 9'd5, 32'h1234_5678, 4'hF, 4'd0, 1'b1);
        issue(1'b0, 9'd5, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t6_perr_inj", 64'(rsp_perr), 64'd1);
        drain("t6_drain_inj");
        issue(1'b1, 9'd5, 32'h1234_5678, 4'hF, 4'd0, 1'b0);
        issue(1'b0, 9'd5, 32'h0, 4'h0, 4'd0, 1'b0);
        check("t6_perr_clean", 64'(rsp_perr), 64'd0);
        drain("t6_drain_clean");
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
